// File: rtl/alu_pkg.sv
// Shared opcode/state types and width constants for the ALU sequencer slice.
package alu_pkg;

  localparam int unsigned RESULT_W = 6;

  typedef enum logic [1:0] {
    OP_SUM = 2'b00,
    OP_RES = 2'b01,
    OP_MUL = 2'b10,
    OP_DIV = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_DONE
  } state_t;

endpackage

// File: rtl/alu_init_decoder.sv
// One-hot launch decoder: turns the registered opcode plus a launch strobe
// into the per-unit init mask (bit 0 sum, 1 subtract, 2 multiply, 3 divide).
import alu_pkg::*;

module alu_init_decoder (
  input  op_t        op,
  input  logic       launch,
  output logic [3:0] init_mask
);

  // Select exactly one unit while the launch strobe is high.
  always_comb begin
    init_mask = '0;
    if (launch) begin
      unique case (op)
        OP_SUM:  init_mask = 4'b0001;
        OP_RES:  init_mask = 4'b0010;
        OP_MUL:  init_mask = 4'b0100;
        OP_DIV:  init_mask = 4'b1000;
        default: init_mask = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_sequencer.sv
// Registered controller between board inputs and the four ALU units.
// Captures operands on start, pulses one init, waits for the unit, latches
// a stable result with sign/error flags.
// Optional macro ALU_TIMEOUT_EN: bounds multiply/divide WAIT to TIMEOUT cycles.
import alu_pkg::*;

module alu_sequencer #(
  parameter int unsigned W       = 3,
  parameter int unsigned RW      = RESULT_W,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [1:0]    opcode,
  input  logic [W-1:0]  a_in,
  input  logic [W-1:0]  b_in,
  output logic [W-1:0]  op_a,
  output logic [W-1:0]  op_b,
  output logic          init_suma,
  output logic          init_resta,
  output logic          init_mult,
  output logic          init_div,
  input  logic [3:0]    sal_suma,
  input  logic [3:0]    sal_resta,
  input  logic          signo_resta,
  input  logic [RW-1:0] sal_mult,
  input  logic          done_mult,
  input  logic [3:0]    sal_div,
  input  logic          done_div,
  output logic [RW-1:0] result,
  output logic          neg,
  output logic          err,
  output logic          busy,
  output logic          done
);

  if (RW != 2 * W) begin : g_bad_rw
    $error("alu_sequencer: RW must equal 2*W");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("alu_sequencer: TIMEOUT must be at least 1");
  end

  state_t     state, state_nxt;
  op_t        op_q;
  logic       div_zero;
  logic       unit_done;
  logic       timed_out;
  logic       launch;
  logic [3:0] init_mask;

  // Divide-by-zero detection on the live inputs and completion of the active unit.
  always_comb begin
    div_zero = (op_t'(opcode) == OP_DIV) && (b_in == '0);
    unique case (op_q)
      OP_MUL:  unit_done = done_mult;
      OP_DIV:  unit_done = done_div;
      default: unit_done = 1'b1;
    endcase
  end

`ifdef ALU_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wait_cnt;

  // WAIT cycle counter; held at zero outside WAIT so it is clear on entry.
  always_ff @(posedge clk) begin
    if (rst || state != S_WAIT) wait_cnt <= '0;
    else                        wait_cnt <= wait_cnt + CW'(1);
  end

  // Abort a handshaking unit after TIMEOUT WAIT cycles without its done.
  always_comb begin
    timed_out = (state == S_WAIT) && !unit_done && (wait_cnt == CW'(TIMEOUT - 1));
  end
`else
  // No timeout: handshaking units are waited on indefinitely.
  always_comb begin
    timed_out = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (start) state_nxt = div_zero ? S_DONE : S_LAUNCH;
      S_LAUNCH: state_nxt = S_WAIT;
      S_WAIT:   if (unit_done || timed_out) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Operand capture on acceptance and result/flag latching on the edge into DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a   <= '0;
      op_b   <= '0;
      op_q   <= OP_SUM;
      result <= '0;
      neg    <= 1'b0;
      err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            op_a <= a_in;
            op_b <= b_in;
            op_q <= op_t'(opcode);
            if (div_zero) begin
              result <= '0;
              neg    <= 1'b0;
              err    <= 1'b1;
            end
          end
        end
        S_WAIT: begin
          if (unit_done) begin
            err <= 1'b0;
            unique case (op_q)
              OP_SUM: begin result <= RW'(sal_suma);  neg <= 1'b0;        end
              OP_RES: begin result <= RW'(sal_resta); neg <= signo_resta; end
              OP_MUL: begin result <= sal_mult;       neg <= 1'b0;        end
              OP_DIV: begin result <= RW'(sal_div);   neg <= 1'b0;        end
              default: begin result <= '0;            neg <= 1'b0;        end
            endcase
          end else if (timed_out) begin
            result <= '0;
            neg    <= 1'b0;
            err    <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs and launch strobe decoded from the current state.
  always_comb begin
    busy   = (state != S_IDLE);
    done   = (state == S_DONE);
    launch = (state == S_LAUNCH);
    {init_div, init_mult, init_resta, init_suma} = init_mask;
  end

  alu_init_decoder u_init_decoder (
    .op        (op_q),
    .launch    (launch),
    .init_mask (init_mask)
  );

endmodule
